imm_encoder: RTL
================

Name: imm_encoder

Overview:
Inverse of the core's immediate decode path. Takes a 32-bit instruction template and a signed 32-bit immediate, and packs the immediate into the I/S/B/J/U field layout. Also expands the LI pseudo-op into a LUI/ADDI pair. Sits in the test-program/trampoline generator feeding the instruction memory writer, with valid/ready on both sides.

Parameters:
- NONE_ERR_CHECK, 0, when 1, range and alignment checks are disabled and out_err is tied 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous assert, active low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  encode kind: ENC_I=0, ENC_S=1, ENC_B=2, ENC_J=3, ENC_U=4, ENC_LI=5; 6,7 reserved
- cmd_base  in  32  template. Opcode, funct, rs/rd fields are kept; immediate bit positions are overwritten. For ENC_LI only [11:7] (rd) is used.
- cmd_imm  in  32  signed immediate value
- out_valid  out  1  encoded word present
- out_ready  in  1  downstream accepts
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range, misaligned, or reserved op
- out_last  out  1  last word of this command (0 only on the LUI of a two-word LI)

Behaviour:
- Reset (rst_n low, async): state=S_IDLE; out_valid=0, out_instr=0, out_err=0, out_last=0; pending register cleared. An in-flight LI is dropped and no ADDI is emitted after reset.
- States:
  - S_IDLE: no output.
  - S_OUT: output valid, out_last=1.
  - S_FIRST: LUI valid, ADDI pending, out_last=0.
- cmd_ready = (state==S_IDLE) | (state==S_OUT & out_ready). It is never high in S_FIRST. This allows back-to-back single-word commands at 1 per cycle.
- Latency: a command accepted at cycle N has its first word on out_* at cycle N+1 (registered output).
- Transitions:
  - IDLE/OUT + accept: LI needing two words -> S_FIRST; otherwise -> S_OUT.
  - S_OUT & out_ready & no accept -> S_IDLE.
  - S_FIRST & out_ready -> S_OUT with the pending ADDI.
- out_valid=0 or out_ready=0: out_instr, out_err and out_last hold stable.
- Field packing (instr[6:0] and non-immediate fields are taken from cmd_base):
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - U: [31:12]=imm[31:12]
- Range and alignment errors (word is still emitted with truncated fields, out_err=1):
  - I/S: imm outside [-2048, 2047]
  - B: imm outside [-4096, 4094] or imm[0]=1
  - J: imm outside [-2^20, 2^20-2] or imm[0]=1
  - U: imm[11:0]!=0
  - reserved op: out_instr=cmd_base, out_err=1, single word
- LI expansion (rd=cmd_base[11:7]):
  - hi = (imm + 0x800)[31:12], computed mod 2^32; lo = imm[11:0].
  - hi==0: one word, ADDI rd,x0,lo.
  - lo==0: one word, LUI rd,hi.
  - otherwise: LUI rd,hi then ADDI rd,rd,lo.
  - LI never errors.
- Simultaneous events: in S_OUT, out_ready and cmd_valid in the same cycle retire the old word and load the new one with no bubble.

Decomposition:
- imm_enc_pkg holds:
  - enc_op_e enum
  - opcode constants OPC_LUI=7'b0110111 and OPC_OPIMM=7'b0010011
  - IMM range limits
  - a pure function pack_imm(op, base, imm) -> {instr, err}
- Sub-module imm_enc_li_split (combinational): imm -> {hi, lo, need_lui, need_addi}. The FSM and output registers stay in imm_encoder.

Test Plan:
- ENC_B, base=0x00208063, imm=-4 -> one word 0xFE208EE3, out_err=0, out_last=1, one cycle after accept.
- ENC_LI, base[11:7]=5, imm=0x12345678 -> 0x123452B7 (out_last=0) then 0x67828293 (out_last=1). cmd_ready is low during the LUI.
- ENC_LI, rd=5, imm=0x00000FFF -> 0x000012B7 then 0xFFF28293. With imm=0x00000010 -> single word 0x01000293.
- ENC_I, base=0x00000013, imm=2048 -> out_err=1, out_instr=0x80000013. ENC_J with imm=3 -> out_err=1.
- Backpressure: out_ready held 0 for 5 cycles mid-LI -> LUI word stable, no new command accepted. On release, ADDI follows next cycle. Back-to-back ENC_I commands with out_ready=1 sustain 1 word/cycle.
- Assert rst_n low while in S_FIRST -> out_valid drops immediately. After release, state is S_IDLE, cmd_ready=1, and no ADDI is emitted.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared types, opcode constants and the single-word immediate packer for imm_encoder.
package imm_enc_pkg;

  typedef enum logic [2:0] {
    ENC_I  = 3'd0,
    ENC_S  = 3'd1,
    ENC_B  = 3'd2,
    ENC_J  = 3'd3,
    ENC_U  = 3'd4,
    ENC_LI = 3'd5
  } enc_op_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  // Signed immediate limits; B/J upper limits are the largest even value.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } pack_res_t;

  // Overwrite the immediate bit positions of base for one-word ops; fields are
  // truncated even when the range/alignment check fails.
  function automatic pack_res_t pack_imm(enc_op_e op, logic [31:0] base, logic [31:0] imm);
    pack_res_t res;
    int        simm;
    simm      = $signed(imm);
    res.instr = base;
    res.err   = 1'b0;
    case (op)
      ENC_I: begin
        res.instr[31:20] = imm[11:0];
        res.err          = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      ENC_S: begin
        res.instr[31:25] = imm[11:5];
        res.instr[11:7]  = imm[4:0];
        res.err          = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      ENC_B: begin
        res.instr[31]    = imm[12];
        res.instr[7]     = imm[11];
        res.instr[30:25] = imm[10:5];
        res.instr[11:8]  = imm[4:1];
        res.err          = (simm < IMM13_MIN) || (simm > IMM13_MAX) || imm[0];
      end
      ENC_J: begin
        res.instr[31]    = imm[20];
        res.instr[30:21] = imm[10:1];
        res.instr[20]    = imm[11];
        res.instr[19:12] = imm[19:12];
        res.err          = (simm < IMM21_MIN) || (simm > IMM21_MAX) || imm[0];
      end
      ENC_U: begin
        res.instr[31:12] = imm[31:12];
        res.err          = (imm[11:0] != 12'd0);
      end
      // Reserved ops pass the template through flagged; LI is expanded elsewhere.
      default: res.err = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Command and output handshake bundle of imm_encoder.
interface imm_encoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_base;
  logic [31:0] cmd_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  // Producer of commands and consumer of encoded words.
  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_imm, out_ready,
    input  cmd_ready, out_valid, out_instr, out_err, out_last
  );

  // The encoder itself.
  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_imm, out_ready,
    output cmd_ready, out_valid, out_instr, out_err, out_last
  );
endinterface

// File: rtl/imm_enc_li_split.sv
// Splits an LI immediate into LUI upper and ADDI lower parts (combinational).
module imm_enc_li_split (
  input  logic [31:0] imm_i,
  output logic [19:0] hi_o,
  output logic [11:0] lo_o,
  output logic        need_lui_o,
  output logic        need_addi_o
);

  logic [19:0] hi;
  logic [11:0] lo;

  // (imm + 0x800) >> 12 reduces to adding bit 11 into the upper field, since the
  // ADDI sign-extends lo and the LUI must compensate.
  always_comb begin
    hi          = imm_i[31:12] + {19'd0, imm_i[11]};
    lo          = imm_i[11:0];
    hi_o        = hi;
    lo_o        = lo;
    need_lui_o  = (hi != 20'd0);
    // With hi == 0 an ADDI from x0 is always emitted, even for imm == 0.
    need_addi_o = (lo != 12'd0) || (hi == 20'd0);
  end

endmodule

// File: rtl/imm_encoder.sv
// Packs signed immediates into RISC-V I/S/B/J/U layouts and expands LI into LUI/ADDI.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int unsigned NONE_ERR_CHECK = 0
) (
  input logic          clk,
  input logic          rst_n,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StOut,
    StFirst
  } state_e;

  localparam bit ErrEn = (NONE_ERR_CHECK == 0);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        li_need_lui;
  logic        li_need_addi;
  logic [4:0]  rd;
  logic [31:0] lui_word;
  logic [31:0] addi_word;
  pack_res_t   pack;
  logic        accept;

  imm_enc_li_split u_li_split (
    .imm_i       (bus.cmd_imm),
    .hi_o        (li_hi),
    .lo_o        (li_lo),
    .need_lui_o  (li_need_lui),
    .need_addi_o (li_need_addi)
  );

  assign bus.cmd_ready = (state_q == StIdle) || ((state_q == StOut) && bus.out_ready);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign bus.out_valid = (state_q != StIdle);
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;
  assign bus.out_last  = last_q;

  // Candidate words for the command currently on the cmd side.
  always_comb begin
    rd        = bus.cmd_base[11:7];
    lui_word  = {li_hi, rd, OPC_LUI};
    // ADDI builds on the LUI result when there is one, otherwise starts from x0.
    addi_word = {li_lo, (li_need_lui ? rd : 5'd0), 3'b000, rd, OPC_OPIMM};
    pack      = pack_imm(enc_op_e'(bus.cmd_op), bus.cmd_base, bus.cmd_imm);
  end

  // Next-state and next-output computation; outputs hold unless retired or reloaded.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    last_d  = last_q;
    pend_d  = pend_q;

    unique case (state_q)
      StFirst: begin
        if (bus.out_ready) begin
          state_d = StOut;
          instr_d = pend_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
        end
      end
      StOut: begin
        if (bus.out_ready && !accept) begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (bus.cmd_op == ENC_LI) begin
        err_d = 1'b0;
        if (li_need_lui && li_need_addi) begin
          state_d = StFirst;
          instr_d = lui_word;
          pend_d  = addi_word;
          last_d  = 1'b0;
        end else begin
          state_d = StOut;
          instr_d = li_need_lui ? lui_word : addi_word;
          last_d  = 1'b1;
        end
      end else begin
        state_d = StOut;
        instr_d = pack.instr;
        err_d   = pack.err && ErrEn;
        last_d  = 1'b1;
      end
    end
  end

  // State and output registers; reset drops any pending ADDI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      instr_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

endmodule
